// File: rtl/jb_ul_dfe_tdm_deinterleave_if.sv
// ----------------------------------------------------------------------------
// jb_ul_dfe_tdm_deinterleave_if
// Stream bundle around the UL TDM deinterleaver.
//   s_tvalid / s_tdata / s_tuser : antenna-interleaved TDM input, one {Q,I}
//                                  sample per beat, tuser = antenna index.
//   m_tvalid / m_tready / m_tdata: parallel frame output, antenna k in
//                                  m_tdata[k*2*PRECISION +: 2*PRECISION].
// Modports:
//   master : upstream/downstream side (drives the TDM input and m_tready).
//   slave  : the deinterleaver itself.
// ----------------------------------------------------------------------------
interface jb_ul_dfe_tdm_deinterleave_if #(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int USR_ID_BW  = 2
);
  logic                              s_tvalid;
  logic [2*PRECISION-1:0]            s_tdata;
  logic [USR_ID_BW-1:0]              s_tuser;
  logic                              m_tvalid;
  logic                              m_tready;
  logic [N_ANTENNAS*2*PRECISION-1:0] m_tdata;

  modport master (
    output s_tvalid, s_tdata, s_tuser, m_tready,
    input  m_tvalid, m_tdata
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tuser, m_tready,
    output m_tvalid, m_tdata
  );
endinterface

// File: rtl/jb_ul_dfe_tdm_deinterleave.sv
// ----------------------------------------------------------------------------
// jb_ul_dfe_tdm_deinterleave
// Reassembles the antenna-interleaved UL TDM stream (clk_4x domain) into one
// parallel word per symbol period, checking the antenna index sequence
// 0..N_ANTENNAS-1 on the way.
//
// Ports:
//   clk_4x       : 491.52 MHz clock.
//   reset_4x     : asynchronous, active-high reset.
//   bus (slave)  : s_tvalid/s_tdata/s_tuser TDM input (no backpressure),
//                  m_tvalid/m_tready/m_tdata parallel frame output.
//   cnt_clr      : synchronous clear of both status counters (wins over inc).
//   seq_err_cnt  : saturating count of index-sequence errors.
//   ovf_cnt      : saturating count of frames dropped on a busy output.
//   locked       : high in COLLECT once a good frame has been delivered.
//
// Optional feature macro: UL_DFE_DEINT_GAP_TIMEOUT_EN
//   When defined, 16 consecutive idle cycles in COLLECT abort the partial
//   frame (back to SEARCH, locked cleared, counted as a sequence error).
//   When undefined, COLLECT waits indefinitely across input gaps.
// ----------------------------------------------------------------------------
module jb_ul_dfe_tdm_deinterleave #(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = 16,
  parameter int USR_ID_BW  = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_4x,
  input  logic                          reset_4x,
  jb_ul_dfe_tdm_deinterleave_if.slave   bus,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              seq_err_cnt,
  output logic [CNT_W-1:0]              ovf_cnt,
  output logic                          locked
);

  localparam int SMP_W = 2 * PRECISION;

  localparam logic [0:0] ST_SEARCH  = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [USR_ID_BW-1:0] IDX_LAST = USR_ID_BW'(N_ANTENNAS - 1);

  logic [0:0]                        state;
  logic [USR_ID_BW-1:0]              exp_idx;
  // The last antenna of a frame goes straight from the input to the output
  // register, so only N_ANTENNAS-1 samples need staging.
  logic [SMP_W-1:0]                  staging [N_ANTENNAS-1];
  logic [N_ANTENNAS*SMP_W-1:0]       frame_word;

  logic in_seq;
  logic complete;
  logic out_free;
  logic load;
  logic drop;
  logic seq_err;
  logic gap_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    frame_word = '0;
    for (int k = 0; k < N_ANTENNAS - 1; k++) begin
      frame_word[k*SMP_W +: SMP_W] = staging[k];
    end
    frame_word[(N_ANTENNAS-1)*SMP_W +: SMP_W] = bus.s_tdata;
  end

  assign in_seq   = (state == ST_COLLECT) && bus.s_tvalid && (bus.s_tuser == exp_idx);
  assign complete = in_seq && (exp_idx == IDX_LAST);
  assign out_free = !bus.m_tvalid || bus.m_tready;
  assign load     = complete && out_free;
  assign drop     = complete && !out_free;
  // Indices >= N_ANTENNAS can never equal exp_idx, so they land here too.
  assign seq_err  = ((state == ST_COLLECT) && bus.s_tvalid && (bus.s_tuser != exp_idx))
                    || gap_timeout;

`ifdef UL_DFE_DEINT_GAP_TIMEOUT_EN
  logic [7:0] gap_cnt;

  // Fires on the 16th consecutive idle cycle spent in COLLECT.
  assign gap_timeout = (state == ST_COLLECT) && !bus.s_tvalid && (gap_cnt == 8'd15);

  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      gap_cnt <= '0;
    end else if ((state == ST_COLLECT) && !bus.s_tvalid && !gap_timeout) begin
      gap_cnt <= gap_cnt + 8'd1;
    end else begin
      gap_cnt <= '0;
    end
  end
`else
  assign gap_timeout = 1'b0;
`endif

  // Sequence tracking and staging
  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      state   <= ST_SEARCH;
      exp_idx <= '0;
      locked  <= 1'b0;
      for (int k = 0; k < N_ANTENNAS - 1; k++) begin
        staging[k] <= '0;
      end
    end else if (gap_timeout) begin
      state   <= ST_SEARCH;
      exp_idx <= '0;
      locked  <= 1'b0;
    end else if (bus.s_tvalid) begin
      case (state)
        ST_SEARCH: begin
          if (bus.s_tuser == '0) begin
            staging[0] <= bus.s_tdata;
            exp_idx    <= USR_ID_BW'(1);
            state      <= ST_COLLECT;
          end
        end
        default: begin
          if (in_seq) begin
            if (complete) begin
              exp_idx <= '0;
              if (load) locked <= 1'b1;
            end else begin
              for (int k = 0; k < N_ANTENNAS - 1; k++) begin
                if (exp_idx == USR_ID_BW'(k)) staging[k] <= bus.s_tdata;
              end
              exp_idx <= exp_idx + USR_ID_BW'(1);
            end
          end else begin
            locked <= 1'b0;
            // An unexpected index 0 is most likely a new frame start, so
            // resynchronise on it directly instead of hunting again.
            if (bus.s_tuser == '0) begin
              staging[0] <= bus.s_tdata;
              exp_idx    <= USR_ID_BW'(1);
            end else begin
              state   <= ST_SEARCH;
              exp_idx <= '0;
            end
          end
        end
      endcase
    end
  end

  // Output register
  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
    end else if (load) begin
      bus.m_tvalid <= 1'b1;
      bus.m_tdata  <= frame_word;
    end else if (bus.m_tready) begin
      bus.m_tvalid <= 1'b0;
    end
  end

  // Status counters
  always_ff @(posedge clk_4x or posedge reset_4x) begin
    if (reset_4x) begin
      seq_err_cnt <= '0;
      ovf_cnt     <= '0;
    end else if (cnt_clr) begin
      seq_err_cnt <= '0;
      ovf_cnt     <= '0;
    end else begin
      if (seq_err) seq_err_cnt <= sat_inc(seq_err_cnt);
      if (drop)    ovf_cnt     <= sat_inc(ovf_cnt);
    end
  end

endmodule

// File: tb/tb_jb_ul_dfe_tdm_deinterleave.sv
module tb_jb_ul_dfe_tdm_deinterleave;

  localparam int N_ANTENNAS = 4;
  localparam int PRECISION  = 16;
  localparam int USR_ID_BW  = 2;
  localparam int CNT_W      = 3;

  logic             clk_4x;
  logic             reset_4x;
  logic             cnt_clr;
  logic [CNT_W-1:0] seq_err_cnt;
  logic [CNT_W-1:0] ovf_cnt;
  logic             locked;

  int checks;
  int failures;

  jb_ul_dfe_tdm_deinterleave_if #(
    .N_ANTENNAS(N_ANTENNAS), .PRECISION(PRECISION), .USR_ID_BW(USR_ID_BW)
  ) bus ();

  jb_ul_dfe_tdm_deinterleave #(
    .N_ANTENNAS(N_ANTENNAS), .PRECISION(PRECISION),
    .USR_ID_BW(USR_ID_BW), .CNT_W(CNT_W)
  ) dut (
    .clk_4x      (clk_4x),
    .reset_4x    (reset_4x),
    .bus         (bus.slave),
    .cnt_clr     (cnt_clr),
    .seq_err_cnt (seq_err_cnt),
    .ovf_cnt     (ovf_cnt),
    .locked      (locked)
  );

  initial clk_4x = 1'b0;
  always #5 clk_4x = ~clk_4x;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [1:0] idx, input logic [15:0] tag, input logic rdy);
    bus.s_tvalid = v;
    bus.s_tuser  = idx;
    bus.s_tdata  = {14'd0, idx, tag};
    bus.m_tready = rdy;
    @(posedge clk_4x);
    #1;
  endtask

  function automatic logic [127:0] exp_frame(input logic [15:0] tag);
    return {16'd3, tag, 16'd2, tag, 16'd1, tag, 16'd0, tag};
  endfunction

  // Full 0..3 frame; beats 0..2 check m_tvalid against mid_vld.
  task automatic frame(input logic [15:0] tag, input logic rdy_mid, input logic rdy_last,
                       input logic mid_vld, input string tag_name);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'(k), tag, rdy_mid);
      chk({tag_name, "_mid_vld"}, {127'd0, bus.m_tvalid}, {127'd0, mid_vld});
    end
    cyc(1'b1, 2'd3, tag, rdy_last);
  endtask

  logic [127:0] lit_a;

  initial begin
    checks   = 0;
    failures = 0;
    lit_a    = 128'h0003000A_0002000A_0001000A_0000000A;
    cnt_clr      = 1'b0;
    reset_4x     = 1'b1;
    bus.s_tvalid = 1'b0;
    bus.s_tuser  = '0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
    repeat (2) @(posedge clk_4x);
    #1;
    chk("rst_vld",    {127'd0, bus.m_tvalid}, 128'd0);
    chk("rst_data",   bus.m_tdata, 128'd0);
    chk("rst_locked", {127'd0, locked}, 128'd0);
    chk("rst_seqerr", {125'd0, seq_err_cnt}, 128'd0);
    chk("rst_ovf",    {125'd0, ovf_cnt}, 128'd0);
    #2 reset_4x = 1'b0;

    // Continuous stream, three frames of 0x000k000A
    for (int f = 0; f < 3; f++) begin
      frame(16'h000A, 1'b1, 1'b1, 1'b0, "cont");
      chk("cont_vld",    {127'd0, bus.m_tvalid}, 128'd1);
      chk("cont_data",   bus.m_tdata, lit_a);
      chk("cont_locked", {127'd0, locked}, 128'd1);
      chk("cont_seqerr", {125'd0, seq_err_cnt}, 128'd0);
      chk("cont_ovf",    {125'd0, ovf_cnt}, 128'd0);
    end

    // 0,1,3 -> error to SEARCH, then a good frame relocks
    cyc(1'b1, 2'd0, 16'h000B, 1'b1);
    chk("skip_vld_clr", {127'd0, bus.m_tvalid}, 128'd0);
    cyc(1'b1, 2'd1, 16'h000B, 1'b1);
    cyc(1'b1, 2'd3, 16'h000B, 1'b1);
    chk("skip_seqerr", {125'd0, seq_err_cnt}, 128'd1);
    chk("skip_locked", {127'd0, locked}, 128'd0);
    chk("skip_vld",    {127'd0, bus.m_tvalid}, 128'd0);
    frame(16'h000C, 1'b1, 1'b1, 1'b0, "relock");
    chk("relock_vld",    {127'd0, bus.m_tvalid}, 128'd1);
    chk("relock_data",   bus.m_tdata, exp_frame(16'h000C));
    chk("relock_locked", {127'd0, locked}, 128'd1);

    // Clear counters, then 0,1,0,1,2,3 restarts in place
    cnt_clr = 1'b1;
    cyc(1'b0, 2'd0, 16'h0000, 1'b1);
    cnt_clr = 1'b0;
    chk("clr_seqerr", {125'd0, seq_err_cnt}, 128'd0);
    cyc(1'b1, 2'd0, 16'h000D, 1'b1);
    cyc(1'b1, 2'd1, 16'h000D, 1'b1);
    cyc(1'b1, 2'd0, 16'h000E, 1'b1);
    chk("restart_seqerr", {125'd0, seq_err_cnt}, 128'd1);
    chk("restart_locked", {127'd0, locked}, 128'd0);
    cyc(1'b1, 2'd1, 16'h000E, 1'b1);
    cyc(1'b1, 2'd2, 16'h000E, 1'b1);
    chk("restart_mid_vld", {127'd0, bus.m_tvalid}, 128'd0);
    cyc(1'b1, 2'd3, 16'h000E, 1'b1);
    chk("restart_vld",  {127'd0, bus.m_tvalid}, 128'd1);
    chk("restart_data", bus.m_tdata, exp_frame(16'h000E));
    cyc(1'b0, 2'd0, 16'h0000, 1'b1);
    chk("restart_single", {127'd0, bus.m_tvalid}, 128'd0);

    // m_tready low for 12 cycles: hold F1, drop F2/F3, F4 reloads with no bubble
    frame(16'h0011, 1'b1, 1'b0, 1'b0, "bp_f1");
    chk("bp_f1_vld",  {127'd0, bus.m_tvalid}, 128'd1);
    chk("bp_f1_data", bus.m_tdata, exp_frame(16'h0011));
    frame(16'h0012, 1'b0, 1'b0, 1'b1, "bp_f2");
    chk("bp_f2_hold", bus.m_tdata, exp_frame(16'h0011));
    chk("bp_f2_ovf",  {125'd0, ovf_cnt}, 128'd1);
    frame(16'h0013, 1'b0, 1'b0, 1'b1, "bp_f3");
    chk("bp_f3_hold", bus.m_tdata, exp_frame(16'h0011));
    chk("bp_f3_ovf",  {125'd0, ovf_cnt}, 128'd2);
    frame(16'h0014, 1'b0, 1'b1, 1'b1, "bp_f4");
    chk("bp_f4_vld",  {127'd0, bus.m_tvalid}, 128'd1);
    chk("bp_f4_data", bus.m_tdata, exp_frame(16'h0014));
    chk("bp_f4_ovf",  {125'd0, ovf_cnt}, 128'd2);
    cyc(1'b0, 2'd0, 16'h0000, 1'b1);
    chk("bp_drain", {127'd0, bus.m_tvalid}, 128'd0);

    // Saturation of the 3-bit error counter, and clear-over-increment priority
    cnt_clr = 1'b1;
    cyc(1'b0, 2'd0, 16'h0000, 1'b1);
    cnt_clr = 1'b0;
    chk("sat_clr_ovf", {125'd0, ovf_cnt}, 128'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 2'd0, 16'h0020, 1'b1);
      cyc(1'b1, 2'd2, 16'h0020, 1'b1);
    end
    chk("sat_seven", {125'd0, seq_err_cnt}, 128'd7);
    cyc(1'b1, 2'd0, 16'h0020, 1'b1);
    cyc(1'b1, 2'd2, 16'h0020, 1'b1);
    chk("sat_hold", {125'd0, seq_err_cnt}, 128'd7);
    cyc(1'b1, 2'd0, 16'h0020, 1'b1);
    cnt_clr = 1'b1;
    cyc(1'b1, 2'd2, 16'h0020, 1'b1);
    cnt_clr = 1'b0;
    chk("clr_priority", {125'd0, seq_err_cnt}, 128'd0);

    // Asynchronous reset mid-frame
    frame(16'h0005, 1'b1, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst_data", bus.m_tdata, exp_frame(16'h0005));
    cyc(1'b1, 2'd0, 16'h0006, 1'b1);
    cyc(1'b1, 2'd1, 16'h0006, 1'b1);
    #2 reset_4x = 1'b1;
    #1;
    chk("arst_vld",    {127'd0, bus.m_tvalid}, 128'd0);
    chk("arst_data",   bus.m_tdata, 128'd0);
    chk("arst_locked", {127'd0, locked}, 128'd0);
    #2 reset_4x = 1'b0;
    cyc(1'b1, 2'd2, 16'h0006, 1'b1);
    cyc(1'b1, 2'd3, 16'h0006, 1'b1);
    chk("arst_ignored_vld", {127'd0, bus.m_tvalid}, 128'd0);
    chk("arst_ignored_err", {125'd0, seq_err_cnt}, 128'd0);
    frame(16'h0007, 1'b1, 1'b1, 1'b0, "post_rst");
    chk("post_rst_vld",  {127'd0, bus.m_tvalid}, 128'd1);
    chk("post_rst_data", bus.m_tdata, exp_frame(16'h0007));

    // 0,1, 16 idle cycles, 2,3
    cyc(1'b1, 2'd0, 16'h0008, 1'b1);
    cyc(1'b1, 2'd1, 16'h0008, 1'b1);
    repeat (16) cyc(1'b0, 2'd0, 16'h0000, 1'b1);
    cyc(1'b1, 2'd2, 16'h0008, 1'b1);
    cyc(1'b1, 2'd3, 16'h0008, 1'b1);
`ifdef UL_DFE_DEINT_GAP_TIMEOUT_EN
    chk("gap_abort_vld", {127'd0, bus.m_tvalid}, 128'd0);
    chk("gap_abort_err", {125'd0, seq_err_cnt}, 128'd1);
    frame(16'h0009, 1'b1, 1'b1, 1'b0, "gap_next");
    chk("gap_next_vld",  {127'd0, bus.m_tvalid}, 128'd1);
    chk("gap_next_data", bus.m_tdata, exp_frame(16'h0009));
`else
    chk("gap_wait_vld",  {127'd0, bus.m_tvalid}, 128'd1);
    chk("gap_wait_data", bus.m_tdata, exp_frame(16'h0008));
    chk("gap_wait_err",  {125'd0, seq_err_cnt}, 128'd0);
`endif

    cyc(1'b0, 2'd0, 16'h0000, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
